// File: rtl/sha1_word_ram.sv
// Word RAM for the SHA-1 datapath: byte-enable writes, 1-cycle registered reads, and a clear sequencer.
// Build option: define SHA1_RAM_WRITE_FIRST_EN for write-first same-address reads (default is read-first).
module sha1_word_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   din,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);
    // Handshake: we/re are sampled on each rising edge while busy=0 and there is no
    // backpressure; dout_valid pulses for exactly one cycle after each accepted re,
    // and every access presented while busy=1 (or alongside clr) is discarded.
    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                wr_hit;
    logic                rd_hit;
    logic                wr_go;
    logic [DATA_W-1:0]   rd_word;

    assign wr_hit = ({1'b0, waddr} < DEPTH_X);
    assign rd_hit = ({1'b0, raddr} < DEPTH_X);
    assign wr_go  = (state == ST_READY) && !clr && we && wr_hit;

`ifdef SHA1_RAM_WRITE_FIRST_EN
    logic [DATA_W-1:0] merged;

    // Same-address bypass: new lanes from din, untouched lanes from the stored word.
    always_comb begin
        merged = mem[raddr];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    assign rd_word = (wr_go && (waddr == raddr)) ? merged : mem[raddr];
`else
    assign rd_word = mem[raddr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    dout_valid <= 1'b0;
                    if (clr) begin
                        ptr <= '0;
                    end else if (ptr == LAST_ADDR) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state      <= ST_CLEAR;
                        ptr        <= '0;
                        busy       <= 1'b1;
                        dout_valid <= 1'b0;
                    end else begin
                        dout_valid <= re;
                        if (re) begin
                            dout <= rd_hit ? rd_word : '0;
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequencer owns zeroing it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR && !clr) begin
                mem[ptr] <= '0;
            end else if (wr_go) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[waddr][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: doc/sha1_word_ram.md
# sha1_word_ram

Parametrised synchronous word RAM for the SHA-1 datapath. It holds message blocks and schedule words (W[t]) between the padding stage and the compression core. It generalises the fixed 32x128 single-write RAM with parametrised width and depth, per-byte write enables, a read-enable/valid handshake, and a hardware clear sequencer that zeroes the array after reset or on request. A configurable read-during-write policy is also provided.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 7, address width.
- DEPTH, 128, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  one-cycle request to re-zero the whole array.
- we  input  1  write strobe.
- be  input  DATA_W/8  byte enables; bit i covers din[8i+7:8i].
- waddr  input  ADDR_W  write address.
- din  input  DATA_W  write data.
- re  input  1  read strobe.
- raddr  input  ADDR_W  read address.
- dout  output  DATA_W  registered read data.
- dout_valid  output  1  high for one cycle when dout carries fresh read data.
- busy  output  1  high while reset or clearing; user accesses ignored.

## Operation
- The FSM has two states: CLEAR and READY.
- Reset (rst=1 at an edge):
  - State goes to CLEAR, clear pointer goes to 0, dout goes to 0, dout_valid goes to 0, busy goes to 1.
  - Array contents are not reset directly; CLEAR zeroes them.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then increments ptr.
  - On the cycle that writes ptr = DEPTH-1, the next state is READY.
  - Total duration is exactly DEPTH cycles after rst deasserts.
  - we and re are ignored; dout holds and dout_valid stays 0.
- READY:
  - busy=0.
  - Write when we=1 and waddr < DEPTH: each byte lane with be[i]=1 is updated and other lanes keep their value. be=0 is a no-op.
  - Read when re=1: dout takes mem[raddr] at the edge and dout_valid=1 next cycle. If raddr ≥ DEPTH, dout=0 and dout_valid=1.
  - When re=0, dout holds its last value and dout_valid=0.
  - Writes with waddr ≥ DEPTH are dropped silently.
- clr=1 in READY: the next state is CLEAR with ptr=0. Any same-cycle we and re are ignored.
- clr=1 during CLEAR: ptr restarts at 0.
- rst mid-CLEAR or mid-access: rst wins and the clear restarts from 0. A pending read result is discarded (dout_valid=0).
- Simultaneous read and write to the same address in READY is resolved per the Configuration section. Read and write to different addresses are independent.

## Timing
- Read latency is 1 cycle: a re sampled at edge N produces dout/dout_valid valid after edge N, i.e. usable at edge N+1. Back-to-back reads sustain one per cycle.
- A write at edge N is visible to a read sampled at edge N+1 regardless of configuration.
- busy is registered:
  - It rises on the edge that samples rst or clr.
  - It falls on the edge that completes the DEPTH-1 clear write.
  - The first accepted access is on the edge after busy reads 0.
- The clear pointer is ADDR_W bits wide and never wraps beyond DEPTH-1.
- Reset values: dout=0, dout_valid=0, busy=1.

## Configuration
- Macro: SHA1_RAM_WRITE_FIRST_EN.
- Defined (write-first): a same-cycle, same-address read returns the merged new word. New bytes come from lanes with be=1 and old bytes from the rest.
- Undefined (read-first): a same-cycle, same-address read returns the pre-write contents.
- No other behaviour changes.

## Test plan
- Reset and clear, default parameters:
  - Pulse rst for 1 cycle; busy must stay 1 for exactly 128 cycles after rst falls.
  - Then read addresses 0..127; every dout must be 0 with dout_valid=1, one cycle after each re.
- Byte lanes:
  - Write 0xDEADBEEF to address 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - Read address 5: dout must be 0xDE22BE44.
- Read-during-write:
  - Address 9 holds 0xAAAAAAAA. Write 0x55555555 (be=4'hF) and read address 9 in the same cycle.
  - dout must be 0x55555555 with the macro defined, and 0xAAAAAAAA without it.
  - A read of address 9 on the next cycle must return 0x55555555 in both configurations.
- Out of range, with DEPTH=100 and ADDR_W=7:
  - A write to address 120 is dropped.
  - A read of address 120 gives dout=0 with dout_valid=1.
  - Address 99 stays writable and readable.
- Mid-operation clear and reset:
  - Fill addresses 0..127 with their own index. Assert clr, then assert rst 40 cycles into CLEAR.
  - busy must stay 1 for 128 cycles after rst falls, and all words must then read 0.
  - Accesses issued while busy=1 must have no effect, and dout_valid must stay 0 while busy.
